// File: rtl/router_input_port.sv
// Router input port: per-VC FIFOs, XY routing, per-output VC arbitration.
// Optional macro INPUT_PORT_ERR_EN adds the sticky err_o flag.
//
// Ports:
//   clk, arst    clock, async active-low reset
//   fin_req_i    upstream flit {valid, vc_id, fdata}
//   fin_resp_o   ready to upstream (!full of presented VC)
//   fout_req_o   one flit per output module, compressed index
//   fout_resp_i  ready from each output module
//   err_o        sticky illegal-route flag (INPUT_PORT_ERR_EN only)

package router_pkg;
  localparam int NUM_VC = 2;
  localparam int VC_W = 1;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } flit_type_t;

  typedef struct packed {
    flit_type_t  type_f;
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [3:0]  pkt_size;
    logic [17:0] payload;
  } s_flit_t;

  typedef struct packed {
    logic            valid;
    logic [VC_W-1:0] vc_id;
    s_flit_t         fdata;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;

  typedef enum logic {
    ZeroHighPrior = 1'b0,
    ZeroLowPrior  = 1'b1
  } prio_t;

  localparam prio_t HighPriority = ZeroLowPrior;
endpackage

module router_input_port
  import router_pkg::*;
#(
  parameter int PORT_DIR     = 0,
  parameter int ROUTER_X_ID  = 0,
  parameter int ROUTER_Y_ID  = 0,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic               clk,
  input  logic               arst,
  input  s_flit_req_t        fin_req_i,
  output s_flit_resp_t       fin_resp_o,
  output s_flit_req_t  [3:0] fout_req_o,
  input  s_flit_resp_t [3:0] fout_resp_i
`ifdef INPUT_PORT_ERR_EN
  ,
  output logic               err_o
`endif
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [2:0] P_DIR = 3'(PORT_DIR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } vc_st_t;

  s_flit_t         r_mem   [NUM_VC][BUFFER_DEPTH];
  logic [PW-1:0]   r_wptr  [NUM_VC];
  logic [PW-1:0]   r_rptr  [NUM_VC];
  vc_st_t          r_state [NUM_VC];
  logic [1:0]      r_route [NUM_VC];
  logic            r_live;

  s_flit_t         w_head  [NUM_VC];
  logic [2:0]      w_dir   [NUM_VC];
  logic [1:0]      w_didx  [NUM_VC];
  logic [1:0]      w_route [NUM_VC];
  logic [NUM_VC-1:0] w_empty;
  logic [NUM_VC-1:0] w_full;
  logic [NUM_VC-1:0] w_legal;
  logic [NUM_VC-1:0] w_req;
  logic [NUM_VC-1:0] w_bad;
  logic [NUM_VC-1:0] w_drop;
  logic [NUM_VC-1:0] w_gnt;
  logic [NUM_VC-1:0] w_pop;
  logic [NUM_VC-1:0] w_push;
  logic [3:0]      w_ovld;
  logic [VC_W-1:0] w_win   [4];
  logic            w_ready;

  // XY order: resolve X first, then Y; 0=N 1=S 2=W 3=E 4=Local
  function automatic logic [2:0] f_dir(input s_flit_t f);
    logic [2:0] d;
    if (int'(f.x_dest) > ROUTER_X_ID)      d = 3'd3;
    else if (int'(f.x_dest) < ROUTER_X_ID) d = 3'd2;
    else if (int'(f.y_dest) > ROUTER_Y_ID) d = 3'd1;
    else if (int'(f.y_dest) < ROUTER_Y_ID) d = 3'd0;
    else                                   d = 3'd4;
    return d;
  endfunction

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_empty[v] = r_wptr[v] == r_rptr[v];
      w_full[v]  = (r_wptr[v][AW] != r_rptr[v][AW]) &&
                   (r_wptr[v][AW-1:0] == r_rptr[v][AW-1:0]);
      w_head[v]  = r_mem[v][r_rptr[v][AW-1:0]];
      w_dir[v]   = f_dir(w_head[v]);
      w_legal[v] = (w_head[v].type_f == HEAD_FLIT) &&
                   (w_dir[v] != P_DIR);
      // the arriving direction has no output, so indices above it shift down
      w_didx[v]  = (w_dir[v] < P_DIR) ? w_dir[v][1:0]
                                      : 2'(w_dir[v] - 3'd1);
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_req[v]   = 1'b0;
      w_bad[v]   = 1'b0;
      w_drop[v]  = 1'b0;
      w_route[v] = r_route[v];
      unique case (r_state[v])
        S_IDLE: begin
          w_req[v]   = !w_empty[v] && w_legal[v];
          w_bad[v]   = !w_empty[v] && !w_legal[v];
          w_drop[v]  = w_bad[v];
          w_route[v] = w_didx[v];
        end
        S_BUSY: w_req[v] = !w_empty[v];
        S_DROP: w_drop[v] = !w_empty[v];
        default: ;
      endcase
    end
  end

  always_comb begin
    fout_req_o = '0;
    for (int o = 0; o < 4; o++) begin
      w_ovld[o] = 1'b0;
      w_win[o]  = '0;
      // later match overwrites earlier, so scan order sets priority
      if (HighPriority == ZeroLowPrior) begin
        for (int v = 0; v < NUM_VC; v++)
          if (w_req[v] && w_route[v] == 2'(o)) begin
            w_ovld[o] = 1'b1;
            w_win[o]  = VC_W'(v);
          end
      end else begin
        for (int v = NUM_VC - 1; v >= 0; v--)
          if (w_req[v] && w_route[v] == 2'(o)) begin
            w_ovld[o] = 1'b1;
            w_win[o]  = VC_W'(v);
          end
      end
      if (w_ovld[o]) begin
        fout_req_o[o].valid = 1'b1;
        fout_req_o[o].vc_id = w_win[o];
        fout_req_o[o].fdata = w_head[w_win[o]];
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      w_gnt[v] = w_req[v] &&
                 (w_win[w_route[v]] == VC_W'(v)) &&
                 fout_resp_i[w_route[v]].ready;
      w_pop[v] = w_gnt[v] || w_drop[v];
    end
  end

  // r_live keeps ready low while in reset
  assign w_ready = r_live && !w_full[fin_req_i.vc_id];
  assign fin_resp_o.ready = w_ready;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++)
      w_push[v] = fin_req_i.valid && w_ready &&
                  (fin_req_i.vc_id == VC_W'(v));
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++)
      if (w_push[v])
        r_mem[v][r_wptr[v][AW-1:0]] <= fin_req_i.fdata;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_live <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        r_wptr[v]  <= '0;
        r_rptr[v]  <= '0;
        r_state[v] <= S_IDLE;
        r_route[v] <= '0;
      end
    end else begin
      r_live <= 1'b1;
      for (int v = 0; v < NUM_VC; v++) begin
        if (w_push[v]) r_wptr[v] <= r_wptr[v] + 1'b1;
        if (w_pop[v])  r_rptr[v] <= r_rptr[v] + 1'b1;
        unique case (r_state[v])
          S_IDLE: begin
            if (!w_empty[v]) begin
              if (w_legal[v]) begin
                r_route[v] <= w_didx[v];
                if (w_gnt[v] && w_head[v].pkt_size != 4'd0)
                  r_state[v] <= S_BUSY;
              end else if (
                w_head[v].type_f == BODY_FLIT ||
                (w_head[v].type_f == HEAD_FLIT &&
                 w_head[v].pkt_size != 4'd0)) begin
                // a lone illegal head or stray tail is already gone
                r_state[v] <= S_DROP;
              end
            end
          end
          S_BUSY: begin
            if (w_gnt[v] && w_head[v].type_f == TAIL_FLIT)
              r_state[v] <= S_IDLE;
          end
          S_DROP: begin
            if (!w_empty[v] && w_head[v].type_f == TAIL_FLIT)
              r_state[v] <= S_IDLE;
          end
          default: r_state[v] <= S_IDLE;
        endcase
      end
    end
  end

`ifdef INPUT_PORT_ERR_EN
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)       err_o <= 1'b0;
    else if (|w_bad) err_o <= 1'b1;
  end
`endif

endmodule
